// File: rtl/ptp_rtc_pkg.sv
// Shared widths and types for the PTP real-time clock.
// Time is held as ns.8f (38 bits) plus 48-bit seconds; the period is 8n.32f (40 bits).
package ptp_rtc_pkg;

  localparam int NS_W   = 38;
  localparam int SEC_W  = 48;
  localparam int PER_W  = 40;
  localparam int RES_W  = 24;
  localparam int STEP_W = PER_W - RES_W;

  typedef logic [NS_W-1:0]   ns8f_t;
  typedef logic [PER_W-1:0]  per8n32f_t;
  typedef logic [SEC_W-1:0]  sec_t;
  typedef logic [STEP_W-1:0] step8n8f_t;

  // Sign-extend an 8n.8f step to the 40-bit working width of the ns adder.
  function automatic per8n32f_t sext_step(input step8n8f_t s);
    return {{(PER_W-STEP_W){s[STEP_W-1]}}, s};
  endfunction

endpackage

// File: rtl/ptp_rtc_step.sv
// Per-cycle step generator: base period plus optional slew offset, reduced to an
// 8n.8f step with the dropped 24-bit fraction carried forward as a residue.
// Build option RTC_DELTA_SIGMA_EN: when defined the residue is carried (exact
// long-term frequency); otherwise the residue stays 0 and the low 24 bits are truncated.
module ptp_rtc_step
  import ptp_rtc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  per8n32f_t period,
  input  per8n32f_t period_adj,
  input  logic      adj_active,
  output step8n8f_t step16
);

`ifdef RTC_DELTA_SIGMA_EN
  localparam bit DS_EN = 1'b1;
`else
  localparam bit DS_EN = 1'b0;
`endif

  logic [RES_W-1:0] resid;
  logic [RES_W-1:0] resid_d;
  per8n32f_t        inc40;
  per8n32f_t        sum40;

  // Add the offset only while a slew is running, then fold in the carried fraction.
  always_comb begin
    inc40   = period + (adj_active ? period_adj : '0);
    sum40   = inc40 + {{(PER_W-RES_W){1'b0}}, resid};
    step16  = sum40[PER_W-1:RES_W];
    resid_d = DS_EN ? sum40[RES_W-1:0] : '0;
  end

  // Residue register; a ToD load restarts the fraction from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      resid <= '0;
    else if (clr) resid <= '0;
    else          resid <= resid_d;
  end

endmodule

// File: rtl/ptp_rtc.sv
// PTP time-of-day counter {sec, ns.8f} advanced every clk by a programmable period,
// with direct ToD load, base-period load and a bounded-length period offset (slew).
// Build option RTC_DELTA_SIGMA_EN selects fraction-residue carrying in ptp_rtc_step.
module ptp_rtc
  import ptp_rtc_pkg::*;
#(
  parameter ns8f_t time_acc_modulo = 38'd256000000000
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             time_ld,
  input  logic [NS_W-1:0]  time_reg_ns_in,
  input  logic [SEC_W-1:0] time_reg_sec_in,
  output logic [NS_W-1:0]  time_reg_ns,
  output logic [SEC_W-1:0] time_reg_sec,
  output logic             time_one_pps,
  output logic [31:0]      time_ptp_ns,
  output logic [SEC_W-1:0] time_ptp_sec,
  input  logic             period_ld,
  input  logic [PER_W-1:0] period_in,
  input  logic             adj_ld,
  input  logic [PER_W-1:0] period_adj,
  input  logic [31:0]      adj_ld_data,
  output logic             adj_ld_done
);

  per8n32f_t   period_q;
  per8n32f_t   adj_off_q;
  logic [31:0] adj_cnt_q;
  ns8f_t       ns_q;
  sec_t        sec_q;
  logic        pps_q;
  logic        done_q;

  step8n8f_t   step16;
  logic        adj_active;
  per8n32f_t   modulo_ext;
  per8n32f_t   ns_sum;
  per8n32f_t   ns_fix;
  logic        ns_neg;
  logic        ns_ovf;

  assign adj_active = (adj_cnt_q != '0);
  assign modulo_ext = {{(PER_W-NS_W){1'b0}}, time_acc_modulo};

  ptp_rtc_step u_step (
    .clk        (clk),
    .rst        (rst),
    .clr        (time_ld),
    .period     (period_q),
    .period_adj (adj_off_q),
    .adj_active (adj_active),
    .step16     (step16)
  );

  // Advance ns by the signed step and decide whether seconds carry or borrow.
  always_comb begin
    ns_sum = {{(PER_W-NS_W){1'b0}}, ns_q} + sext_step(step16);
    ns_neg = ns_sum[PER_W-1];
    ns_ovf = !ns_neg && (ns_sum >= modulo_ext);
    ns_fix = ns_sum;
    if (ns_neg)      ns_fix = ns_sum + modulo_ext;
    else if (ns_ovf) ns_fix = ns_sum - modulo_ext;
  end

  // Time-of-day accumulator; a ToD load replaces this cycle's increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ns_q  <= '0;
      sec_q <= '0;
      pps_q <= 1'b0;
    end else if (time_ld) begin
      ns_q  <= time_reg_ns_in;
      sec_q <= time_reg_sec_in;
      pps_q <= 1'b0;
    end else begin
      ns_q  <= ns8f_t'(ns_fix);
      pps_q <= ns_ovf;
      if (ns_ovf)      sec_q <= sec_q + 1'b1;
      else if (ns_neg) sec_q <= sec_q - 1'b1;
    end
  end

  // Base period register; a new value applies from the next increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            period_q <= '0;
    else if (period_ld) period_q <= period_in;
  end

  // Slew counter: a new request restarts the run, done marks a run that finished naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adj_off_q <= '0;
      adj_cnt_q <= '0;
      done_q    <= 1'b0;
    end else if (adj_ld) begin
      adj_off_q <= period_adj;
      adj_cnt_q <= adj_ld_data;
      done_q    <= (adj_ld_data == '0);
    end else begin
      done_q <= (adj_cnt_q == 32'd1);
      if (adj_active) adj_cnt_q <= adj_cnt_q - 1'b1;
    end
  end

  assign time_reg_ns  = ns_q;
  assign time_reg_sec = sec_q;
  assign time_one_pps = pps_q;
  assign time_ptp_ns  = {2'b00, ns_q[NS_W-1:8]};
  assign time_ptp_sec = sec_q;
  assign adj_ld_done  = done_q;

endmodule

// File: tb/tb_ptp_rtc.sv
// Self-checking bench for ptp_rtc with a 1000 ns "second" (modulo 256000).
// A cycle model pushes the expected state into a scoreboard as each cycle is driven;
// it is popped and compared once the DUT has clocked that cycle.
module tb_ptp_rtc;

  localparam logic [37:0] MOD_V = 38'd256000;
  localparam longint MOD  = 256000;
  localparam longint M40  = 64'h00FF_FFFF_FFFF;
  localparam longint M48  = 64'h0000_FFFF_FFFF_FFFF;
`ifdef RTC_DELTA_SIGMA_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        time_ld;
  logic [37:0] time_reg_ns_in;
  logic [47:0] time_reg_sec_in;
  logic [37:0] time_reg_ns;
  logic [47:0] time_reg_sec;
  logic        time_one_pps;
  logic [31:0] time_ptp_ns;
  logic [47:0] time_ptp_sec;
  logic        period_ld;
  logic [39:0] period_in;
  logic        adj_ld;
  logic [39:0] period_adj;
  logic [31:0] adj_ld_data;
  logic        adj_ld_done;

  ptp_rtc #(.time_acc_modulo(MOD_V)) dut (
    .clk             (clk),
    .rst             (rst),
    .time_ld         (time_ld),
    .time_reg_ns_in  (time_reg_ns_in),
    .time_reg_sec_in (time_reg_sec_in),
    .time_reg_ns     (time_reg_ns),
    .time_reg_sec    (time_reg_sec),
    .time_one_pps    (time_one_pps),
    .time_ptp_ns     (time_ptp_ns),
    .time_ptp_sec    (time_ptp_sec),
    .period_ld       (period_ld),
    .period_in       (period_in),
    .adj_ld          (adj_ld),
    .period_adj      (period_adj),
    .adj_ld_data     (adj_ld_data),
    .adj_ld_done     (adj_ld_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint ns;
    longint sec;
    bit     pps;
    bit     done;
  } exp_t;

  exp_t   sb_q[$];
  longint m_ns, m_sec, m_resid, m_period, m_adj, m_cnt;
  int     checks, errors, pps_seen, done_seen;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare the DUT after the edge.
  task automatic applyStimulus(input bit tl, input longint ns_in, input longint sec_in,
                               input bit pl, input longint per,
                               input bit al, input longint adj, input longint len);
    exp_t   e;
    longint inc, s, step, nsn;
    time_ld         = tl;
    time_reg_ns_in  = ns_in[37:0];
    time_reg_sec_in = sec_in[47:0];
    period_ld       = pl;
    period_in       = per[39:0];
    adj_ld          = al;
    period_adj      = adj[39:0];
    adj_ld_data     = len[31:0];

    inc  = (m_period + ((m_cnt != 0) ? m_adj : 64'd0)) & M40;
    s    = (inc + m_resid) & M40;
    step = (s >> 24) & 64'hFFFF;
    if (step >= 32768) step = step - 65536;
    if (tl) begin
      m_ns = ns_in; m_sec = sec_in; m_resid = 0; e.pps = 1'b0;
    end else begin
      nsn   = m_ns + step;
      e.pps = 1'b0;
      if (nsn >= MOD) begin
        nsn = nsn - MOD; m_sec = (m_sec + 1) & M48; e.pps = 1'b1;
      end else if (nsn < 0) begin
        nsn = nsn + MOD; m_sec = (m_sec - 1) & M48;
      end
      m_ns    = nsn;
      m_resid = DS ? (s & 64'hFF_FFFF) : 64'd0;
    end
    e.done = al ? (len == 0) : (m_cnt == 1);
    m_cnt  = al ? len : ((m_cnt != 0) ? m_cnt - 1 : 64'd0);
    if (al) m_adj = adj;
    if (pl) m_period = per;
    e.ns  = m_ns;
    e.sec = m_sec;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    time_ld = 1'b0; period_ld = 1'b0; adj_ld = 1'b0;
    e = sb_q.pop_front();
    checkOutput("ns",      time_reg_ns,  e.ns);
    checkOutput("sec",     time_reg_sec, e.sec);
    checkOutput("pps",     time_one_pps, e.pps);
    checkOutput("done",    adj_ld_done,  e.done);
    checkOutput("ptp_ns",  time_ptp_ns,  e.ns >> 8);
    checkOutput("ptp_sec", time_ptp_sec, e.sec);
    pps_seen  += int'(time_one_pps);
    done_seen += int'(adj_ld_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    longint per, adj;
    checks = 0; errors = 0; pps_seen = 0; done_seen = 0;
    m_ns = 0; m_sec = 0; m_resid = 0; m_period = 0; m_adj = 0; m_cnt = 0;
    time_ld = 0; time_reg_ns_in = '0; time_reg_sec_in = '0;
    period_ld = 0; period_in = '0; adj_ld = 0; period_adj = '0; adj_ld_data = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ns",   time_reg_ns,  0);
    checkOutput("rst_sec",  time_reg_sec, 0);
    checkOutput("rst_pps",  time_one_pps, 0);
    checkOutput("rst_done", adj_ld_done,  0);
    rst = 1'b0;

    // No loads: time stays at zero.
    idle(20);
    checkOutput("idle_ns", time_reg_ns, 0);
    checkOutput("idle_pps_cnt", pps_seen, 0);
    checkOutput("idle_done_cnt", done_seen, 0);

    // 8 ns period from 900 ns / sec 10: second rolls after 13 clocks.
    applyStimulus(0, 0, 0, 1, 64'h08_0000_0000, 0, 0, 0);
    applyStimulus(1, 900*256, 10, 0, 0, 0, 0, 0);
    pps_seen = 0;
    idle(12);
    checkOutput("t2_ns_996", time_reg_ns, 996*256);
    checkOutput("t2_sec_10", time_reg_sec, 10);
    idle(1);
    checkOutput("t2_ns_4", time_reg_ns, 4*256);
    checkOutput("t2_sec_11", time_reg_sec, 11);
    checkOutput("t2_pps_cnt", pps_seen, 1);

    // Positive slew: +16 ns/clk for 100 clocks, one done pulse.
    applyStimulus(1, 0, 20, 0, 0, 0, 0, 0);
    done_seen = 0;
    applyStimulus(0, 0, 0, 0, 0, 1, 64'h08_0000_0000, 100);
    idle(100);
    checkOutput("t3_ns", time_reg_ns, 608*256);
    checkOutput("t3_sec", time_reg_sec, 21);
    idle(10);
    checkOutput("t3_done_cnt", done_seen, 1);

    // Negative slew: -8 ns/clk crosses zero and borrows a second, no pps.
    applyStimulus(1, 400*256, 5, 0, 0, 0, 0, 0);
    pps_seen = 0; done_seen = 0;
    applyStimulus(0, 0, 0, 0, 0, 1, 64'hF0_0000_0000, 100);
    idle(52);
    checkOutput("t4_ns_992", time_reg_ns, 992*256);
    checkOutput("t4_sec_4", time_reg_sec, 4);
    idle(60);
    checkOutput("t4_pps_cnt", pps_seen, 0);
    checkOutput("t4_done_cnt", done_seen, 1);

    // Restart mid-run: only the second run reports done; zero length reports at once.
    done_seen = 0;
    applyStimulus(0, 0, 0, 0, 0, 1, 64'h08_0000_0000, 10);
    idle(5);
    applyStimulus(0, 0, 0, 0, 0, 1, 64'h08_0000_0000, 3);
    idle(10);
    checkOutput("restart_done_cnt", done_seen, 1);
    done_seen = 0;
    applyStimulus(0, 0, 0, 0, 0, 1, 64'h08_0000_0000, 0);
    checkOutput("zero_len_done", adj_ld_done, 1);
    idle(3);
    checkOutput("zero_len_done_cnt", done_seen, 1);

    // Seconds wrap at 2^48 and borrow back below zero.
    applyStimulus(1, 999*256, 64'hFFFF_FFFF_FFFF, 0, 0, 0, 0, 0);
    idle(1);
    checkOutput("sec_wrap_sec", time_reg_sec, 0);
    checkOutput("sec_wrap_ns", time_reg_ns, 7*256);
    applyStimulus(0, 0, 0, 0, 0, 1, 64'hF0_0000_0000, 2);
    idle(2);
    checkOutput("sec_borrow_sec", time_reg_sec, 64'hFFFF_FFFF_FFFF);

    // Fractional period over 256 clocks (2064.125 ns with residue, 2064 ns truncated).
    applyStimulus(1, 0, 0, 1, 64'h08_1020_0000, 0, 0, 0);
    idle(256);
    checkOutput("t5_ns", time_reg_ns, DS ? 16416 : 16384);
    checkOutput("t5_sec", time_reg_sec, 2);

    // ToD load and slew start together: load wins, slew runs from next cycle.
    applyStimulus(0, 0, 0, 1, 64'h08_0000_0000, 0, 0, 0);
    done_seen = 0;
    applyStimulus(1, 100*256, 7, 0, 0, 1, 64'h08_0000_0000, 5);
    checkOutput("t6_load_ns", time_reg_ns, 100*256);
    idle(5);
    checkOutput("t6_adj_ns", time_reg_ns, 180*256);
    idle(1);
    checkOutput("t6_base_ns", time_reg_ns, 188*256);
    checkOutput("t6_done_cnt", done_seen, 1);

    // Random mix of loads, slews and period changes checked by the model.
    for (int i = 0; i < 300; i++) begin
      per = ((longint'($urandom_range(1, 20)) << 32) | longint'($urandom)) & M40;
      adj = (((longint'($urandom_range(0, 31)) - 16) << 32) | longint'($urandom)) & M40;
      applyStimulus($urandom_range(0, 19) == 0, longint'($urandom_range(0, 255999)),
                    longint'($urandom), $urandom_range(0, 9) == 0, per,
                    $urandom_range(0, 14) == 0, adj, longint'($urandom_range(0, 12)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
